floor_scroll_renderer: RTL and testbench

//   Pixel-pipeline stage between VGA timing and floor_tile_rom. Maps each
//   (hcount, vcount) in the floor band to an 8x8 tile texel (rom_row/rom_col),

---
 rtl/floor_scroll_renderer.sv | 107 ++++++++++
 tb/tb_floor_scroll_renderer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/floor_scroll_renderer.sv
// Floor-band pixel stage: maps (hcount, vcount) to an 8x8 tile texel with a per-frame
// horizontal scroll, then registers the returned ROM colour alongside the delayed video flags.
module floor_scroll_renderer #(
    parameter int          FLOOR_TOP  = 400,
    parameter int          SCALE_LOG2 = 2,
    parameter logic [11:0] BG_COLOR   = 12'h000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       video_on,
    input  logic       frame_start,
    input  logic       scroll_en,
    input  logic       scroll_dir,
    input  logic [3:0] scroll_speed,
    output logic [2:0] rom_row,
    output logic [2:0] rom_col,
    input  logic [3:0] rom_r,
    input  logic [3:0] rom_g,
    input  logic [3:0] rom_b,
    output logic [3:0] R,
    output logic [3:0] G,
    output logic [3:0] B,
    output logic       pix_valid,
    output logic       floor_hit
);

    localparam logic [9:0] FLOOR_TOP_V = 10'(FLOOR_TOP);

    logic [9:0]  scroll_x_q, scroll_x_d;
    logic [2:0]  rom_row_q, rom_row_d;
    logic [2:0]  rom_col_q, rom_col_d;
    logic        on_d1_q, on_d1_d;
    logic        in_floor_d1_q, in_floor_d1_d;
    logic [11:0] rgb_q, rgb_d;
    logic        pix_valid_q, pix_valid_d;
    logic        floor_hit_q, floor_hit_d;

    logic [9:0]  u;
    logic [9:0]  v;

    // Scroll offset only moves on the frame boundary, so a frame is always drawn with one offset.
    always_comb begin
        scroll_x_d = scroll_x_q;
        if (frame_start && scroll_en) begin
            if (scroll_dir)
                scroll_x_d = scroll_x_q - {6'd0, scroll_speed};
            else
                scroll_x_d = scroll_x_q + {6'd0, scroll_speed};
        end
    end

    // Stage 1: texel address; the 10-bit add wraps cleanly since the tile period divides 1024.
    always_comb begin
        u             = hcount + scroll_x_q;
        v             = vcount - FLOOR_TOP_V;
        rom_col_d     = 3'((u >> SCALE_LOG2) & 10'd7);
        rom_row_d     = 3'((v >> SCALE_LOG2) & 10'd7);
        on_d1_d       = video_on;
        in_floor_d1_d = (vcount >= FLOOR_TOP_V);
    end

    // Stage 2: select colour source using the flags that travelled with the address.
    always_comb begin
        rgb_d = 12'h000;
        if (on_d1_q) begin
            if (in_floor_d1_q)
                rgb_d = {rom_r, rom_g, rom_b};
            else
                rgb_d = BG_COLOR;
        end
        pix_valid_d = on_d1_q;
        floor_hit_d = on_d1_q & in_floor_d1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scroll_x_q    <= 10'd0;
            rom_row_q     <= 3'd0;
            rom_col_q     <= 3'd0;
            on_d1_q       <= 1'b0;
            in_floor_d1_q <= 1'b0;
            rgb_q         <= 12'h000;
            pix_valid_q   <= 1'b0;
            floor_hit_q   <= 1'b0;
        end else begin
            scroll_x_q    <= scroll_x_d;
            rom_row_q     <= rom_row_d;
            rom_col_q     <= rom_col_d;
            on_d1_q       <= on_d1_d;
            in_floor_d1_q <= in_floor_d1_d;
            rgb_q         <= rgb_d;
            pix_valid_q   <= pix_valid_d;
            floor_hit_q   <= floor_hit_d;
        end
    end

    assign rom_row   = rom_row_q;
    assign rom_col   = rom_col_q;
    assign R         = rgb_q[11:8];
    assign G         = rgb_q[7:4];
    assign B         = rgb_q[3:0];
    assign pix_valid = pix_valid_q;
    assign floor_hit = floor_hit_q;

endmodule

// File: tb/tb_floor_scroll_renderer.sv
// Directed bench for floor_scroll_renderer: a small tile-ROM model drives the texel colour,
// expected pixels go into a scoreboard queue and are checked two clocks later.
module tb_floor_scroll_renderer;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] hcount, vcount;
    logic       video_on, frame_start, scroll_en, scroll_dir;
    logic [3:0] scroll_speed;
    logic [2:0] rom_row, rom_col;
    logic [3:0] rom_r, rom_g, rom_b;
    logic [3:0] R, G, B;
    logic       pix_valid, floor_hit;

    floor_scroll_renderer #(
        .FLOOR_TOP (400),
        .SCALE_LOG2(2),
        .BG_COLOR  (12'h00F)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hcount      (hcount),
        .vcount      (vcount),
        .video_on    (video_on),
        .frame_start (frame_start),
        .scroll_en   (scroll_en),
        .scroll_dir  (scroll_dir),
        .scroll_speed(scroll_speed),
        .rom_row     (rom_row),
        .rom_col     (rom_col),
        .rom_r       (rom_r),
        .rom_g       (rom_g),
        .rom_b       (rom_b),
        .R           (R),
        .G           (G),
        .B           (B),
        .pix_valid   (pix_valid),
        .floor_hit   (floor_hit)
    );

    always #5 clk = ~clk;

    // Tile ROM model: columns 0/1 give 6/3/x, column 2 gives 8/5/x; blue encodes the row.
    function automatic logic [11:0] rom_model(input logic [2:0] row, input logic [2:0] col);
        logic [3:0] half;
        half = {2'b00, col[2:1]};
        return {4'd6 + 4'd2 * half, 4'd3 + 4'd2 * half, 4'd2 + {1'b0, row}};
    endfunction

    assign {rom_r, rom_g, rom_b} = rom_model(rom_row, rom_col);

    typedef struct {
        int         due;
        logic [11:0] rgb;
        logic       valid;
        logic       hit;
    } exp_t;

    exp_t       sbq[$];
    int         cyc = 0;
    int         checks = 0;
    int         passes = 0;
    int         fails = 0;
    logic [9:0] sx = 10'd0;
    logic [2:0] exp_col, exp_row;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            check("rgb", 16'({R, G, B}), 16'(e.rgb));
            check("flags", 16'({pix_valid, floor_hit}), 16'({e.valid, e.hit}));
        end
    endtask

    // Drive one pixel for the next edge and record what must come out two clocks later.
    task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic on);
        exp_t       e;
        logic [9:0] uu, vv;
        hcount   = h;
        vcount   = v;
        video_on = on;
        uu       = h + sx;
        vv       = v - 10'd400;
        exp_col  = uu[4:2];
        exp_row  = vv[4:2];
        e.due    = cyc + 2;
        if (!on) begin
            e.rgb = 12'h000; e.valid = 1'b0; e.hit = 1'b0;
        end else if (v < 10'd400) begin
            e.rgb = 12'h00F; e.valid = 1'b1; e.hit = 1'b0;
        end else begin
            e.rgb = rom_model(exp_row, exp_col); e.valid = 1'b1; e.hit = 1'b1;
        end
        sbq.push_back(e);
    endtask

    task automatic frame(input logic en, input logic dir, input logic [3:0] spd);
        scroll_en    = en;
        scroll_dir   = dir;
        scroll_speed = spd;
        frame_start  = 1'b1;
        drive(10'd5, 10'd300, 1'b0);
        tick();
        frame_start = 1'b0;
        if (en) sx = dir ? sx - {6'd0, spd} : sx + {6'd0, spd};
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        sbq.delete();
        hcount = 10'd0; vcount = 10'd400; video_on = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            check("rst_rgb", 16'({R, G, B}), 16'h0);
            check("rst_flags", 16'({pix_valid, floor_hit}), 16'h0);
        end
        sx    = 10'd0;
        reset = 1'b0;
        drive(10'd0, 10'd400, 1'b1);
        tick();
        check("post_rst_rgb", 16'({R, G, B}), 16'h0);
        check("post_rst_flags", 16'({pix_valid, floor_hit}), 16'h0);
        check("rst_scroll", 16'(dut.scroll_x_q), 16'(sx));
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; scroll_en = 1'b0; scroll_dir = 1'b0;
        scroll_speed = 4'd0; hcount = 10'd0; vcount = 10'd0; video_on = 1'b1;

        // Reset with video active
        do_reset(3);

        // Floor texels at scroll 0
        drive(10'd0, 10'd400, 1'b1); tick(); check("col_h0", 16'(rom_col), 16'(exp_col));
        drive(10'd4, 10'd400, 1'b1); tick(); check("col_h4", 16'(rom_col), 16'(exp_col));
        drive(10'd8, 10'd400, 1'b1); tick(); check("col_h8", 16'(rom_col), 16'(exp_col));
        drive(10'd37, 10'd413, 1'b1); tick(); check("row_v413", 16'(rom_row), 16'(exp_row));
        drive(10'd479, 10'd479, 1'b1); tick();

        // Background and blanking
        drive(10'd50, 10'd100, 1'b1); tick();
        drive(10'd51, 10'd399, 1'b1); tick();
        drive(10'd52, 10'd100, 1'b0); tick();
        drive(10'd53, 10'd450, 1'b0); tick();

        // Forward scroll by 5 three times, then a pixel at hcount 1
        frame(1'b1, 1'b0, 4'd5);
        frame(1'b1, 1'b0, 4'd5);
        frame(1'b1, 1'b0, 4'd5);
        check("scroll_15", 16'(dut.scroll_x_q), 16'(sx));
        drive(10'd1, 10'd400, 1'b1); tick(); check("col_scroll", 16'(rom_col), 16'(exp_col));

        // Pixel in flight across a scroll update keeps the old offset
        drive(10'd9, 10'd404, 1'b1);
        scroll_en = 1'b1; scroll_dir = 1'b0; scroll_speed = 4'd8; frame_start = 1'b1;
        tick();
        frame_start = 1'b0; sx = sx + 10'd8;
        drive(10'd9, 10'd404, 1'b1); tick();

        // Wrap both ways
        frame(1'b1, 1'b1, 4'd15);
        frame(1'b1, 1'b1, 4'd8);
        frame(1'b1, 1'b1, 4'd2);
        check("scroll_1022", 16'(dut.scroll_x_q), 16'(sx));
        frame(1'b1, 1'b0, 4'd3);
        check("scroll_wrap_up", 16'(dut.scroll_x_q), 16'(sx));
        frame(1'b1, 1'b1, 4'd2);
        check("scroll_wrap_dn", 16'(dut.scroll_x_q), 16'(sx));
        drive(10'd1, 10'd400, 1'b1); tick(); check("col_wrap", 16'(rom_col), 16'(exp_col));
        drive(10'd20, 10'd431, 1'b1); tick();

        // Holds: disabled update and zero speed
        frame(1'b0, 1'b0, 4'd7);
        frame(1'b1, 1'b0, 4'd0);
        check("scroll_hold", 16'(dut.scroll_x_q), 16'(sx));

        // Reset mid-frame
        drive(10'd100, 10'd420, 1'b1); tick();
        do_reset(1);
        drive(10'd12, 10'd400, 1'b1); tick();
        drive(10'd0, 10'd0, 1'b0); tick();
        drive(10'd0, 10'd0, 1'b0); tick();
        tick();
        check("queue_drained", 16'(sbq.size()), 16'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
